// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch sequencer: steers the PC on EXE-stage redirects, drives the
// imem request handshake and fills IF/ID, parking a fetch accepted during a freeze.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        flush
);

  typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] kill_addr, kill_addr_nxt;
  logic [31:0] buf_instr, buf_instr_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] if_pc_nxt, if_instr_nxt;
  logic        if_valid_nxt;
  logic        accept;
  logic [31:0] pc_inc;

  // 32-bit modulo increment; the top of the address space wraps to zero.
  function automatic logic [31:0] step_pc(input logic [31:0] a);
    return a + PC_STEP;
  endfunction

  assign pc_inc    = step_pc(pc);
  assign imem_req  = rst_n && (state != HOLD);
  // KILL keeps presenting the stale address until memory completes it.
  assign imem_addr = (state == KILL) ? kill_addr : pc;
  assign flush     = rst_n && Br_taken;
  assign accept    = imem_req && imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    kill_addr_nxt = kill_addr;
    buf_instr_nxt = buf_instr;
    buf_pc_nxt    = buf_pc;
    if_pc_nxt     = if_pc;
    if_instr_nxt  = if_instr;
    if_valid_nxt  = if_valid;
    case (state)
      FETCH: begin
        if (Br_taken) begin
          pc_nxt       = Br_addr;
          if_valid_nxt = 1'b0;
          if (!accept) begin
            kill_addr_nxt = pc;
            state_nxt     = KILL;
          end
        end else if (accept && !freeze) begin
          if_instr_nxt = imem_rdata;
          if_pc_nxt    = pc_inc;
          if_valid_nxt = 1'b1;
          pc_nxt       = pc_inc;
        end else if (accept) begin
          buf_instr_nxt = imem_rdata;
          buf_pc_nxt    = pc_inc;
          pc_nxt        = pc_inc;
          state_nxt     = HOLD;
        end else if (!freeze) begin
          if_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (Br_taken) begin
          pc_nxt       = Br_addr;
          if_valid_nxt = 1'b0;
          state_nxt    = FETCH;
        end else if (!freeze) begin
          if_instr_nxt = buf_instr;
          if_pc_nxt    = buf_pc;
          if_valid_nxt = 1'b1;
          state_nxt    = FETCH;
        end
      end
      KILL: begin
        if (accept) state_nxt = FETCH;
        // A second redirect while the stale request drains: latest target wins.
        if (Br_taken) begin
          pc_nxt       = Br_addr;
          if_valid_nxt = 1'b0;
        end else if (!freeze) begin
          if_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      kill_addr <= '0;
      buf_instr <= '0;
      buf_pc    <= '0;
      if_pc     <= '0;
      if_instr  <= '0;
      if_valid  <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      kill_addr <= kill_addr_nxt;
      buf_instr <= buf_instr_nxt;
      buf_pc    <= buf_pc_nxt;
      if_pc     <= if_pc_nxt;
      if_instr  <= if_instr_nxt;
      if_valid  <= if_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench for fetch_redirect_unit: expected IF/ID entries are queued as
// fetches are driven and checked as each instruction leaves IF/ID.
module tb_fetch_redirect_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        Br_taken = 1'b0;
  logic [31:0] Br_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        flush;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  fetch_redirect_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .Br_taken(Br_taken), .Br_addr(Br_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F00 ^ {a[15:0], a[31:16]};
  endfunction

  assign imem_rdata = word(imem_addr);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic fz, input logic br, input logic [31:0] ba, input logic rdy);
    @(posedge clk);
    #1;
    freeze = fz;
    Br_taken = br;
    Br_addr = ba;
    imem_ready = rdy;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  // An IF/ID entry leaves when ID consumes it (no freeze) or a redirect kills it.
  always @(negedge clk) begin
    if (rst_n && if_valid && (!freeze || Br_taken)) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_pc", if_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("sb_pc", if_pc, e.pc);
        check_val("sb_instr", if_instr, e.instr);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset: outputs quiet even with a branch asserted.
    Br_taken = 1'b1;
    Br_addr = 32'h1234;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", 32'(imem_req), 0);
    check_val("rst_flush", 32'(flush), 0);
    check_val("rst_valid", 32'(if_valid), 0);
    check_val("rst_if_pc", if_pc, 0);
    check_val("rst_if_instr", if_instr, 0);
    Br_taken = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Sequential zero-wait fetch from RESET_PC.
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1);
      push_exp(32'(i * 4 + 4), word(32'(i * 4)));
      @(negedge clk);
      check_val("seq_addr", imem_addr, 32'(i * 4));
      check_val("seq_req", 32'(imem_req), 1);
      if (i == 0) check_val("seq_valid0", 32'(if_valid), 0);
      if (i == 1) begin
        check_val("seq_valid1", 32'(if_valid), 1);
        check_val("seq_if_pc1", if_pc, 4);
      end
    end

    // Redirect with zero-wait memory at pc=0x20.
    drive(0, 1, 32'h100, 1);
    @(negedge clk);
    check_val("br_flush", 32'(flush), 1);
    check_val("br_addr_cur", imem_addr, 32'h20);
    drive(0, 0, 0, 1);
    push_exp(32'h104, word(32'h100));
    @(negedge clk);
    check_val("br_tgt_addr", imem_addr, 32'h100);
    check_val("br_bubble", 32'(if_valid), 0);
    drive(0, 0, 0, 1);
    push_exp(32'h108, word(32'h104));
    @(negedge clk);
    check_val("br_if_pc", if_pc, 32'h104);
    check_val("br_valid", 32'(if_valid), 1);

    // Redirect during a stalled request at 0x40.
    drive(0, 1, 32'h40, 1);
    @(negedge clk);
    drive(0, 0, 0, 0);
    @(negedge clk);
    check_val("stall_addr0", imem_addr, 32'h40);
    check_val("stall_valid", 32'(if_valid), 0);
    drive(0, 1, 32'h200, 0);
    @(negedge clk);
    check_val("stall_addr1", imem_addr, 32'h40);
    check_val("stall_flush", 32'(flush), 1);
    drive(0, 0, 0, 0);
    @(negedge clk);
    check_val("kill_addr2", imem_addr, 32'h40);
    check_val("kill_req", 32'(imem_req), 1);
    drive(0, 0, 0, 1);
    @(negedge clk);
    check_val("kill_addr3", imem_addr, 32'h40);
    drive(0, 0, 0, 1);
    push_exp(32'h204, word(32'h200));
    @(negedge clk);
    check_val("kill_next_addr", imem_addr, 32'h200);
    check_val("kill_no_stale", 32'(if_valid), 0);

    // Freeze during accepted fetch of 0x60.
    drive(0, 1, 32'h5C, 1);
    @(negedge clk);
    drive(0, 0, 0, 1);
    push_exp(32'h60, word(32'h5C));
    @(negedge clk);
    check_val("frz_pre_addr", imem_addr, 32'h5C);
    drive(1, 0, 0, 1);
    push_exp(32'h64, word(32'h60));
    @(negedge clk);
    check_val("frz_addr", imem_addr, 32'h60);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 1);
      @(negedge clk);
      check_val("frz_req", 32'(imem_req), 0);
      check_val("frz_if_pc", if_pc, 32'h60);
      check_val("frz_if_instr", if_instr, word(32'h5C));
    end
    drive(0, 0, 0, 1);
    @(negedge clk);
    check_val("rel_req", 32'(imem_req), 0);
    drive(0, 0, 0, 1);
    push_exp(32'h68, word(32'h64));
    @(negedge clk);
    check_val("rel_if_pc", if_pc, 32'h64);
    check_val("rel_if_instr", if_instr, word(32'h60));
    check_val("rel_addr", imem_addr, 32'h64);
    check_val("rel_req1", 32'(imem_req), 1);

    // Redirect while holding a buffered fetch.
    drive(1, 0, 0, 1);
    @(negedge clk);
    check_val("hold_addr", imem_addr, 32'h68);
    drive(1, 1, 32'h300, 1);
    @(negedge clk);
    check_val("hold_br_flush", 32'(flush), 1);
    check_val("hold_br_req", 32'(imem_req), 0);
    drive(0, 0, 0, 1);
    push_exp(32'h304, word(32'h300));
    @(negedge clk);
    check_val("hold_br_addr", imem_addr, 32'h300);
    check_val("hold_br_valid", 32'(if_valid), 0);
    drive(0, 0, 0, 1);
    push_exp(32'h308, word(32'h304));
    @(negedge clk);
    check_val("hold_br_if_pc", if_pc, 32'h304);

    // PC wrap at the top of the address space.
    drive(0, 1, 32'hFFFF_FFFC, 1);
    @(negedge clk);
    drive(0, 0, 0, 1);
    push_exp(32'h0, word(32'hFFFF_FFFC));
    @(negedge clk);
    check_val("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    drive(0, 1, 32'h80, 1);
    @(negedge clk);
    check_val("wrap_addr", imem_addr, 32'h0);
    check_val("wrap_if_pc", if_pc, 32'h0);

    // Asynchronous reset mid-request at 0x80.
    drive(0, 0, 0, 0);
    @(negedge clk);
    check_val("ar_addr", imem_addr, 32'h80);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("ar_req", 32'(imem_req), 0);
    check_val("ar_valid", 32'(if_valid), 0);
    check_val("ar_if_pc", if_pc, 0);
    check_val("ar_pc", imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 1);
    push_exp(32'h4, word(32'h0));
    @(negedge clk);
    check_val("ar_first_addr", imem_addr, 32'h0);
    check_val("ar_first_req", 32'(imem_req), 1);
    drive(0, 0, 0, 0);
    @(negedge clk);
    check_val("ar_if_pc1", if_pc, 32'h4);
    drive(0, 0, 0, 0);
    @(negedge clk);
    check_val("ar_bubble", 32'(if_valid), 0);

    check_val("sb_drain", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
